// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
) ();
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order credit-limited requests to instruction
// memory, a small prefetch FIFO, and redirect handling with wrong-path drop.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    PC_TYPE_NUM = 4,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [$clog2(PC_TYPE_NUM)-1:0] pc_sel,
  input  logic [ADDR_WIDTH-1:0]          bra_addr,
  input  logic [ADDR_WIDTH-1:0]          jal_addr,
  input  logic [ADDR_WIDTH-1:0]          jar_addr,
  fetch_unit_if.master                   imem,
  output logic                           inst_valid,
  output logic [INST_WIDTH-1:0]          inst_word,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [ADDR_WIDTH-1:0]          pc4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic                  redirect_q, redirect_d;

  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] word_mem [FIFO_DEPTH];

  logic [PC_TYPE_NUM-1:0][ADDR_WIDTH-1:0] target_src;
  logic [ADDR_WIDTH-1:0] target_sel;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW:0]           credit_sum;
  logic                  redirect_take;
  logic                  req;
  logic                  grant;
  logic                  resp;
  logic                  push;
  logic                  pop;
  logic                  head_valid;

  // Source 0 is sequential fetch; it never reaches the target path.
  generate
    for (genvar gi = 0; gi < PC_TYPE_NUM; gi++) begin : g_target_src
      if (gi == 1) begin : g_bra
        assign target_src[gi] = bra_addr;
      end else if (gi == 2) begin : g_jal
        assign target_src[gi] = jal_addr;
      end else if (gi == 3) begin : g_jar
        assign target_src[gi] = jar_addr;
      end else begin : g_seq
        assign target_src[gi] = fetch_pc_q;
      end
    end
  endgenerate

  assign target_sel      = target_src[pc_sel];
  assign redirect_target = target_sel & ~ADDR_WIDTH'(3);
  assign redirect_take   = !reset && !stall && (pc_sel != '0);

  assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req        = !reset && !redirect_q && (credit_sum < (CW + 1)'(FIFO_DEPTH));
  assign grant      = req && imem.imem_gnt;
  // Responses with nothing outstanding belong to requests forgotten by reset.
  assign resp       = imem.imem_rvalid && !reset && (outstanding_q != '0);
  assign push       = resp && (drop_cnt_q == '0) && !redirect_take;

  assign head_valid = !reset && (count_q != '0) && !redirect_take;
  assign pop        = head_valid && !stall;

  assign imem.imem_req  = req;
  assign imem.imem_addr = fetch_pc_q;

  assign inst_valid = head_valid;
  assign inst_word  = head_valid ? word_mem[rd_ptr_q] : NOP;
  assign pc         = head_valid ? pc_mem[rd_ptr_q] : '0;
  assign pc4        = head_valid ? pc_mem[rd_ptr_q] + ADDR_WIDTH'(4) : '0;

  always_comb begin
    fetch_pc_d    = grant ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + ADDR_WIDTH'(4) : resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    drop_cnt_d    = (resp && (drop_cnt_q != '0)) ? drop_cnt_q - CW'(1) : drop_cnt_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    redirect_d    = redirect_take;
    if (redirect_take) begin
      // Everything still in flight after this edge is wrong-path.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      drop_cnt_d = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      redirect_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      redirect_q    <= redirect_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      word_mem[wr_ptr_q] <= imem.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects and mid-run reset
// against an in-order instruction memory returning addr[31:0] as data.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [63:0] bra_addr, jal_addr, jar_addr;
  logic        inst_valid;
  logic [31:0] inst_word;
  logic [63:0] pc, pc4;

  fetch_unit_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) imem_bus ();

  fetch_unit #(
    .ADDR_WIDTH(64), .INST_WIDTH(32), .PC_TYPE_NUM(4), .FIFO_DEPTH(4), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
    .bra_addr(bra_addr), .jal_addr(jal_addr), .jar_addr(jar_addr),
    .imem(imem_bus),
    .inst_valid(inst_valid), .inst_word(inst_word), .pc(pc), .pc4(pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic        resp_en;
  logic [63:0] q_addr[$];
  int          q_due[$];

  logic        mon_valid, mon_req;
  logic [31:0] mon_word;
  logic [63:0] mon_pc, mon_pc4, mon_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive this cycle's response, sample at negedge, advance.
  task automatic step();
    if (resp_en && q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = q_addr[0][31:0];
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    mon_valid = inst_valid;
    mon_word  = inst_word;
    mon_pc    = pc;
    mon_pc4   = pc4;
    mon_req   = imem_bus.imem_req;
    mon_addr  = imem_bus.imem_addr;
    if (imem_bus.imem_req && imem_bus.imem_gnt) begin
      q_addr.push_back(imem_bus.imem_addr);
      q_due.push_back(cyc + mem_lat);
    end
    $display("cycle %0d: req=%0b addr=%h valid=%0b pc=%h word=%h", cyc, mon_req, mon_addr,
             mon_valid, mon_pc, mon_word);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] p);
    logic [63:0] pw;
    pw = p;
    check({tag, ".valid"}, {63'd0, mon_valid}, {63'd0, v});
    if (v) begin
      check({tag, ".pc"}, mon_pc, pw);
      check({tag, ".pc4"}, mon_pc4, pw + 64'd4);
      check({tag, ".word"}, {32'd0, mon_word}, {32'd0, pw[31:0]});
    end else begin
      check({tag, ".nop"}, {32'd0, mon_word}, {32'd0, NOP});
      check({tag, ".pc0"}, mon_pc, 64'd0);
      check({tag, ".pc4_0"}, mon_pc4, 64'd0);
    end
  endtask

  task automatic expect_req(input string tag, input logic r, input logic [63:0] a);
    check({tag, ".req"}, {63'd0, mon_req}, {63'd0, r});
    if (r) check({tag, ".addr"}, mon_addr, a);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'd0;
    bra_addr = '0; jal_addr = '0; jar_addr = '0;
    resp_en = 1'b1;
    imem_bus.imem_gnt = 1'b1; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;

    // Reset
    step(); step();
    expect_req("reset", 1'b0, 64'd0);
    expect_out("reset", 1'b0, 64'd0);
    reset = 1'b0;

    // Streaming, 1-cycle latency
    step(); expect_req("c1", 1'b1, 64'd0); expect_out("c1", 1'b0, 64'd0);
    step(); expect_req("c2", 1'b1, 64'd4); expect_out("c2", 1'b0, 64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      expect_out("stream", 1'b1, 64'(4 * k));
      expect_req("stream", 1'b1, 64'(4 * (k + 2)));
    end

    // Stall for 6 cycles: head held, credit caps in-flight words at 4
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("stall_hold", 1'b1, 64'd24);
      if (i < 2) expect_req("stall_issue", 1'b1, 64'(32 + 4 * i));
      else       expect_req("stall_credit", 1'b0, 64'd0);
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("release", 1'b1, 64'(24 + 4 * i));
      if (i == 0) expect_req("release_full", 1'b0, 64'd0);
      if (i == 1) expect_req("release_issue", 1'b1, 64'd40);
    end

    // Redirect (jal 0x1002) with 3 outstanding, request abandoned
    resp_en = 1'b0;
    step(); expect_out("drain0", 1'b1, 64'd48); expect_req("drain0", 1'b1, 64'd60);
    step(); expect_out("drain1", 1'b1, 64'd52); expect_req("drain1", 1'b1, 64'd64);
    pc_sel = 2'd2; jal_addr = 64'h1002; imem_bus.imem_gnt = 1'b0;
    step(); expect_out("jal_cycle", 1'b0, 64'd0); expect_req("jal_cycle", 1'b1, 64'd68);
    pc_sel = 2'd0; imem_bus.imem_gnt = 1'b1; resp_en = 1'b1;
    step(); expect_req("jal_r1", 1'b0, 64'd0);     expect_out("jal_r1", 1'b0, 64'd0);
    step(); expect_req("jal_r2", 1'b1, 64'h1000);  expect_out("jal_r2", 1'b0, 64'd0);
    step(); expect_req("jal_r3", 1'b1, 64'h1004);  expect_out("jal_drop", 1'b0, 64'd0);
    step(); expect_out("jal_push", 1'b0, 64'd0);
    step(); expect_out("jal_target", 1'b1, 64'h1000);
    step(); expect_out("jal_next", 1'b1, 64'h1004);

    // Stalled redirect ignored, taken next cycle together with a response
    stall = 1'b1; pc_sel = 2'd1; bra_addr = 64'h2000;
    step(); expect_out("bra_stalled", 1'b1, 64'h1008); expect_req("bra_stalled", 1'b1, 64'h1014);
    stall = 1'b0;
    step(); expect_out("bra_cycle", 1'b0, 64'd0); expect_req("bra_credit", 1'b0, 64'd0);
    pc_sel = 2'd0;
    step(); expect_req("bra_r1", 1'b0, 64'd0); expect_out("bra_r1", 1'b0, 64'd0);
    step(); expect_req("bra_r2", 1'b1, 64'h2000); expect_out("bra_r2", 1'b0, 64'd0);
    step(); expect_req("bra_r3", 1'b1, 64'h2004); expect_out("bra_r3", 1'b0, 64'd0);
    step(); expect_out("bra_target", 1'b1, 64'h2000);
    step(); expect_out("bra_next", 1'b1, 64'h2004);

    // Redirect (jar 0x3007) with non-empty FIFO, a grant and a response
    pc_sel = 2'd3; jar_addr = 64'h3007;
    step(); expect_out("jar_suppress", 1'b0, 64'd0); expect_req("jar_cycle", 1'b1, 64'h2010);
    pc_sel = 2'd0;
    step(); expect_req("jar_r1", 1'b0, 64'd0); expect_out("jar_r1", 1'b0, 64'd0);
    step(); expect_req("jar_r2", 1'b1, 64'h3004); expect_out("jar_r2", 1'b0, 64'd0);
    step(); expect_out("jar_r3", 1'b0, 64'd0);
    step(); expect_out("jar_target", 1'b1, 64'h3004);

    // Reset with 2 outstanding; stale responses arrive after reset falls
    resp_en = 1'b0;
    step(); expect_out("pre_reset", 1'b1, 64'h3008); expect_req("pre_reset", 1'b1, 64'h3010);
    reset = 1'b1; imem_bus.imem_gnt = 1'b0;
    step(); expect_req("mid_reset", 1'b0, 64'd0); expect_out("mid_reset", 1'b0, 64'd0);
    reset = 1'b0; resp_en = 1'b1;
    step(); expect_req("stale0", 1'b1, 64'd0); expect_out("stale0", 1'b0, 64'd0);
    step(); expect_req("stale1", 1'b1, 64'd0); expect_out("stale1", 1'b0, 64'd0);
    imem_bus.imem_gnt = 1'b1;
    step(); expect_req("restart", 1'b1, 64'd0); expect_out("restart", 1'b0, 64'd0);
    step(); expect_req("restart1", 1'b1, 64'd4); expect_out("restart1", 1'b0, 64'd0);
    step(); expect_out("restart_pc0", 1'b1, 64'd0);
    step(); expect_out("restart_pc4", 1'b1, 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
